// File: rtl/bus_arb_pkg.sv
// Shared types and defaults for the round-robin bus arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ADDR_PHASE = 2'd1,
        DATA_PHASE = 2'd2
    } state_t;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;

    // Width of a master index; never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first eligible index searching upward from last+1.
module rr_picker
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = idx_w(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] elig,
    input  logic [IDX_W-1:0]       last,
    output logic [NUM_MASTERS-1:0] pick,
    output logic                   any
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        pick = '0;
        any  = 1'b0;
        idx  = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = IDX_W'((int'(last) + k) % NUM_MASTERS);
            if (!any && elig[idx]) begin
                pick[idx] = 1'b1;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one valid/ready slave among NUM_MASTERS masters,
// with a per-transaction watchdog that aborts grants on a stalled slave.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT     = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_MASTERS-1:0]        m_valid,
    input  logic [NUM_MASTERS-1:0]        m_read,
    input  logic [NUM_MASTERS-1:0]        m_write,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]        m_ready,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [NUM_MASTERS-1:0]        m_error,
    output logic [NUM_MASTERS-1:0]        grant,
    output logic                          s_valid,
    output logic                          s_read,
    output logic                          s_write,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    input  logic                          s_ready,
    input  logic [DATA_W-1:0]             s_rdata,
    output logic [1:0]                    dbg_state
);

    localparam int IDX_W = idx_w(NUM_MASTERS);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int LIM   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    state_t                   state_q, state_d;
    logic [NUM_MASTERS-1:0]   grant_q, grant_d;
    logic [NUM_MASTERS-1:0]   error_q, error_d;
    logic [IDX_W-1:0]         last_q, last_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic [NUM_MASTERS-1:0]   elig;
    logic [NUM_MASTERS-1:0]   pick;
    logic                     pick_any;
    logic [IDX_W-1:0]         gidx;
    logic                     in_phase;
    logic                     g_valid;
    logic                     handshake;
    logic                     wd_hit;

    assign elig = m_valid & (m_read ^ m_write);

    rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .elig (elig),
        .last (last_q),
        .pick (pick),
        .any  (pick_any)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) gidx = IDX_W'(i);
        end
    end

    assign in_phase  = (state_q != IDLE);
    assign g_valid   = m_valid[gidx];
    assign handshake = in_phase && g_valid && s_ready;
    // Fires on the edge that would complete TIMEOUT stalled cycles in a phase.
    assign wd_hit    = (TIMEOUT > 0) && (cnt_q == CNT_W'(LIM));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        error_d = '0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pick_any) begin
                    grant_d = pick;
                    state_d = ADDR_PHASE;
                end
            end
            ADDR_PHASE, DATA_PHASE: begin
                if (!g_valid || (!handshake && wd_hit) ||
                    (handshake && state_q == DATA_PHASE)) begin
                    if (g_valid && !handshake) error_d = grant_q;
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = gidx;
                    cnt_d   = '0;
                end else if (handshake) begin
                    state_d = DATA_PHASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            error_q <= '0;
            last_q  <= IDX_W'(NUM_MASTERS - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            error_q <= error_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant     = grant_q;
    assign m_error   = error_q;
    assign m_ready   = grant_q & {NUM_MASTERS{s_ready}};
    assign m_rdata   = s_rdata;
    assign dbg_state = state_q;

    assign s_valid = in_phase & m_valid[gidx];
    assign s_read  = in_phase & m_read[gidx];
    assign s_write = in_phase & m_write[gidx];
    assign s_addr  = in_phase ? m_addr[int'(gidx) * ADDR_W +: ADDR_W] : '0;
    assign s_wdata = in_phase ? m_wdata[int'(gidx) * DATA_W +: DATA_W] : '0;

endmodule
